// File: rtl/pipe_pkg.sv
// Shared types for pipeline stage boundaries: stage occupancy states and the
// ID/EX control/data bundle layouts with their field encodings.
package pipe_pkg;

  typedef enum logic [1:0] {
    STAGE_EMPTY = 2'd0,
    STAGE_FULL  = 2'd1,
    STAGE_SKID  = 2'd2
  } stage_state_e;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] MEM_TO_REG_ALU = 2'd0;
  localparam logic [1:0] MEM_TO_REG_MEM = 2'd1;
  localparam logic [1:0] MEM_TO_REG_PC  = 2'd2;

  // rsvd pads the 11 architectural control bits to a 12-bit bundle.
  typedef struct packed {
    logic       rsvd;
    logic       reg_write;
    logic [2:0] alu_control;
    logic       alu_src;
    logic [1:0] reg_dst;
    logic       mem_write;
    logic       mem_read;
    logic [1:0] mem_to_reg;
  } idex_ctrl_t;

  typedef struct packed {
    logic [15:0] pc_plus1;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [15:0] imm;
  } idex_data_t;

  localparam int IDEX_CTRL_W = $bits(idex_ctrl_t);
  localparam int IDEX_DATA_W = $bits(idex_data_t);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable; sticks at all-ones until reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = W'(1'b1);

  logic [W-1:0] count_r;

  // Count enabled cycles, holding once the maximum is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline-stage register with optional 2-entry skid buffer,
// flush-to-bubble and a saturating stall-cycle counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = IDEX_CTRL_W,
  parameter int DATA_W = IDEX_DATA_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  stage_state_e      state_r;
  logic [CTRL_W-1:0] main_ctrl_r;
  logic [DATA_W-1:0] main_data_r;
  logic              in_ready_r;
  logic              out_valid_r;

  logic [CTRL_W-1:0] skid_ctrl_s;
  logic [DATA_W-1:0] skid_data_s;
  logic              skid_load_s;
  logic              skid_pop_s;
  logic              stall_inc_s;

  // Skid load/pop strobes and stall detection, shared by the FSM and skid register.
  always_comb begin
    skid_load_s = 1'b0;
    skid_pop_s  = 1'b0;
    if (!flush && (SKID != 0)) begin
      skid_load_s = (state_r == STAGE_FULL) && in_valid && !out_ready;
      skid_pop_s  = (state_r == STAGE_SKID) && out_ready;
    end else begin
      skid_load_s = 1'b0;
      skid_pop_s  = 1'b0;
    end
    stall_inc_s = out_valid_r && !out_ready;
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [CTRL_W-1:0] skid_ctrl_r;
      logic [DATA_W-1:0] skid_data_r;

      // Second slot catches the input that arrives while downstream stalls.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          skid_ctrl_r <= '0;
          skid_data_r <= '0;
        end else if (flush || skid_pop_s) begin
          skid_ctrl_r <= '0;
          skid_data_r <= '0;
        end else if (skid_load_s) begin
          skid_ctrl_r <= in_ctrl;
          skid_data_r <= in_data;
        end
      end

      assign skid_ctrl_s = skid_ctrl_r;
      assign skid_data_s = skid_data_r;
    end else begin : g_no_skid
      assign skid_ctrl_s = '0;
      assign skid_data_s = '0;
    end
  endgenerate

  // Occupancy FSM owning the main register; vacated or flushed slots become zero bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= STAGE_EMPTY;
      main_ctrl_r <= '0;
      main_data_r <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else if (flush) begin
      state_r     <= STAGE_EMPTY;
      main_ctrl_r <= '0;
      main_data_r <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        STAGE_EMPTY: begin
          if (in_valid) begin
            main_ctrl_r <= in_ctrl;
            main_data_r <= in_data;
            state_r     <= STAGE_FULL;
            out_valid_r <= 1'b1;
          end
        end
        STAGE_FULL: begin
          if (in_valid && out_ready) begin
            main_ctrl_r <= in_ctrl;
            main_data_r <= in_data;
          end else if (skid_load_s) begin
            state_r    <= STAGE_SKID;
            in_ready_r <= 1'b0;
          end else if (!in_valid && out_ready) begin
            main_ctrl_r <= '0;
            main_data_r <= '0;
            state_r     <= STAGE_EMPTY;
            out_valid_r <= 1'b0;
          end
        end
        STAGE_SKID: begin
          if (out_ready) begin
            main_ctrl_r <= skid_ctrl_s;
            main_data_r <= skid_data_s;
            state_r     <= STAGE_FULL;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= STAGE_EMPTY;
          main_ctrl_r <= '0;
          main_data_r <= '0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Without a skid slot, ready must see this cycle's out_ready to keep full throughput.
  assign in_ready  = (SKID != 0) ? in_ready_r : (!out_valid_r || out_ready);
  assign out_valid = out_valid_r;
  assign out_ctrl  = main_ctrl_r;
  assign out_data  = main_data_r;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc_s),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: skid and non-skid instances,
// vector table plus scoreboard on every output transfer.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int CW   = 12;
  localparam int DW   = 73;
  localparam int CNTW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            flush, in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0]   in_ctrl, out_ctrl;
  logic [DW-1:0]   in_data, out_data;
  logic [CNTW-1:0] stall_cnt;

  logic            flush0, iv0, ir0, ov0, or0;
  logic [CW-1:0]   ic0, oc0;
  logic [DW-1:0]   id0, od0;
  logic [CNTW-1:0] sc0;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(CNTW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .stall_cnt(stall_cnt));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(CNTW)) dut0 (
    .clk(clk), .rst(rst), .flush(flush0), .in_valid(iv0), .in_ready(ir0),
    .in_ctrl(ic0), .in_data(id0), .out_valid(ov0), .out_ready(or0),
    .out_ctrl(oc0), .out_data(od0), .stall_cnt(sc0));

  int checks = 0;
  int failures = 0;
  logic [CW+DW-1:0] q[$];
  logic [CW+DW-1:0] q0[$];

  typedef struct {
    bit iv; bit ordy; bit fl; int k;
    bit e_ir; bit e_ov; int e_k; int e_st;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [CW-1:0] make_ctrl(int k);
    return CW'(k * 5 + 3);
  endfunction

  function automatic logic [DW-1:0] make_data(int k);
    logic [DW-1:0] d;
    d = {16'(k), 41'(k * 7 + 1), 16'(k)};
    return d;
  endfunction

  function automatic logic [CW+DW-1:0] item(int k);
    return {make_ctrl(k), make_data(k)};
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(bit iv, bit ordy, bit fl, int k, bit e_ir, bit e_ov, int e_k, int e_st);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.k = k;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_k = e_k; v.e_st = e_st;
    vecs.push_back(v);
  endtask

  // Scoreboard evaluation at negedge, then advance to just after the next posedge.
  task automatic cycle();
    logic [CW+DW-1:0] e;
    @(negedge clk);
    if (!rst) begin
      if (flush) q.delete();
      else begin
        if (out_valid && out_ready) begin
          checks++;
          if (q.size() == 0) begin
            failures++;
            $display("FAIL sb_skid unexpected actual=%0h expected=none", {out_ctrl, out_data});
          end else begin
            e = q.pop_front();
            if ({out_ctrl, out_data} !== e) begin
              failures++;
              $display("FAIL sb_skid actual=%0h expected=%0h", {out_ctrl, out_data}, e);
            end
          end
        end
        if (in_valid && in_ready) q.push_back({in_ctrl, in_data});
      end
      if (flush0) q0.delete();
      else begin
        if (ov0 && or0) begin
          checks++;
          if (q0.size() == 0) begin
            failures++;
            $display("FAIL sb_noskid unexpected actual=%0h expected=none", {oc0, od0});
          end else begin
            e = q0.pop_front();
            if ({oc0, od0} !== e) begin
              failures++;
              $display("FAIL sb_noskid actual=%0h expected=%0h", {oc0, od0}, e);
            end
          end
        end
        if (iv0 && ir0) q0.push_back({ic0, id0});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit iv, bit ordy, bit fl, int k);
    in_valid = iv; out_ready = ordy; flush = fl;
    in_ctrl = make_ctrl(k); in_data = make_data(k);
  endtask

  task automatic drive0(bit iv, bit ordy, int k);
    iv0 = iv; or0 = ordy; ic0 = make_ctrl(k); id0 = make_data(k);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush0 = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 0);
    drive0(1'b0, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_bundle", {out_ctrl, out_data}, '0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_stall_cnt", stall_cnt, '0);
    chk("rst_in_ready0", ir0, 1'b1);
    rst = 1'b0;

    // stream 1..4
    for (int k = 1; k <= 4; k++) add(1, 1, 0, k, 1, 1, k, 0);
    add(0, 1, 0, 0, 1, 0, 0, 0);
    // back-pressure with skid: A=10, B=11, C=12 held off
    add(1, 0, 0, 10, 1, 1, 10, 0);
    add(1, 0, 0, 11, 0, 1, 10, 1);
    add(1, 0, 0, 12, 0, 1, 10, 2);
    add(1, 0, 0, 12, 0, 1, 10, 3);
    add(0, 1, 0, 0,  1, 1, 11, 3);
    add(0, 1, 0, 0,  1, 0, 0,  3);
    // flush in SKID state with C=22 present; 23 accepted next cycle
    add(1, 0, 0, 20, 1, 1, 20, 3);
    add(1, 0, 0, 21, 0, 1, 20, 4);
    add(1, 0, 1, 22, 1, 0, 0,  5);
    add(1, 1, 0, 23, 1, 1, 23, 5);
    add(0, 1, 0, 0,  1, 0, 0,  5);

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].k);
      cycle();
      chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_ir);
      chk($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_ov);
      chk($sformatf("v%0d_out", i), {out_ctrl, out_data},
          vecs[i].e_ov ? item(vecs[i].e_k) : '0);
      chk($sformatf("v%0d_stall", i), stall_cnt, CNTW'(vecs[i].e_st));
    end
    drive(1'b0, 1'b0, 1'b0, 0);

    // stall counter saturation: 5 + 20 stall cycles clamps at 15
    drive(1'b1, 1'b0, 1'b0, 30);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 0);
    repeat (20) cycle();
    chk("sat_stall_cnt", stall_cnt, 4'd15);
    chk("sat_out_hold", {out_ctrl, out_data}, item(30));
    drive(1'b0, 1'b1, 1'b0, 0);
    cycle();
    chk("sat_drained", out_valid, 1'b0);
    chk("sat_stall_kept", stall_cnt, 4'd15);

    // non-skid instance: combinational in_ready, B held upstream
    drive0(1'b1, 1'b0, 50);
    #1 chk("ns_ready_empty", ir0, 1'b1);
    cycle();
    chk("ns_out_a", {ov0, oc0, od0}, {1'b1, item(50)});
    drive0(1'b1, 1'b0, 51);
    #1 chk("ns_ready_stall", ir0, 1'b0);
    cycle();
    chk("ns_hold_a", {oc0, od0}, item(50));
    chk("ns_stall1", sc0, 4'd1);
    repeat (2) cycle();
    chk("ns_stall3", sc0, 4'd3);
    or0 = 1'b1;
    #1 chk("ns_ready_follow", ir0, 1'b1);
    cycle();
    chk("ns_out_b", {ov0, oc0, od0}, {1'b1, item(51)});
    drive0(1'b0, 1'b1, 0);
    cycle();
    chk("ns_empty", {ov0, oc0, od0}, '0);
    drive0(1'b0, 1'b0, 0);

    // asynchronous reset between edges while occupied
    drive(1'b1, 1'b1, 1'b0, 40);
    cycle();
    chk("ar_pre_valid", {out_valid, out_ctrl, out_data}, {1'b1, item(40)});
    drive(1'b1, 1'b1, 1'b0, 41);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", out_valid, 1'b0);
    chk("ar_out_bundle", {out_ctrl, out_data}, '0);
    chk("ar_in_ready", in_ready, 1'b1);
    chk("ar_stall_cnt", stall_cnt, '0);
    chk("ar_stall_cnt0", sc0, '0);
    q.delete();
    q0.delete();
    drive(1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 1'b0, 42);
    cycle();
    chk("ar_recover", {out_valid, out_ctrl, out_data}, {1'b1, item(42)});
    drive(1'b0, 1'b1, 1'b0, 0);
    cycle();
    chk("ar_recover_empty", out_valid, 1'b0);
    chk("sb_drained", q.size(), 0);
    chk("sb0_drained", q0.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
